// File: rtl/px_pkg.sv
// Shared types and constants for the P-X state sequencer.
// The sequencer phases, the default phase lengths and the helper
// that sizes the phase and timeout counters all live here.
package px_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S1    = 3'd1,
    WBUS  = 3'd2,
    S2    = 3'd3,
    WSTEP = 3'd4,
    GOT   = 3'd5
  } px_seq_t;

  localparam int DEF_T_S1    = 4;
  localparam int DEF_T_S1L   = 6;
  localparam int DEF_T_S2    = 3;
  localparam int DEF_T_GOT   = 2;
  localparam int DEF_T_ALARM = 250;

  // Width needed to hold the largest of the timing constants.
  function automatic int cnt_width(input int t_s1, input int t_s1l, input int t_s2,
                                   input int t_got, input int t_alarm);
    int m;
    m = t_s1;
    if (t_s1l > m) m = t_s1l;
    if (t_s2 > m) m = t_s2;
    if (t_got > m) m = t_got;
    if (t_alarm > m) m = t_alarm;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/px_seq_if.sv
// System-bus handshake between the sequencer and the bus arbiter.
// The sequencer is the master: it raises ZG and reports the outcome of
// each transaction (OK pulse, EN flag, sticky alarm).
interface px_seq_if;

  logic zg;
  logic zw;
  logic ren;
  logic rok;
  logic ok;
  logic en_flag;
  logic alarm;

  modport master (
    output zg,
    output ok,
    output en_flag,
    output alarm,
    input  zw,
    input  ren,
    input  rok
  );

  modport slave (
    input  zg,
    input  ok,
    input  en_flag,
    input  alarm,
    output zw,
    output ren,
    output rok
  );

endinterface

// File: rtl/px_phase_cnt.sv
// Loadable down-counter used to time sequencer phases and the bus timeout.
// done is high while the count is on its last cycle (1) or exhausted (0),
// so a phase loaded with N lasts N enabled cycles.
module px_phase_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt;

  // Load wins over counting; the count parks at zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt <= W'(1));

endmodule

// File: rtl/px_seq.sv
// P-X state sequencer and strobe generator.
// Walks each instruction state through STROB1, an optional bus
// transaction, an optional STROB2, an optional panel step wait and GOT,
// at which point the decode logic's next-state vector is taken.
module px_seq
  import px_pkg::*;
#(
  parameter int                 NSTATES     = 32,
  parameter logic [NSTATES-1:0] RESET_STATE = {{(NSTATES-1){1'b0}}, 1'b1},
  parameter logic [NSTATES-1:0] LONG_MASK   = '0,
  parameter logic [NSTATES-1:0] S2_MASK     = '1,
  parameter logic [NSTATES-1:0] BUS_MASK    = '0,
  parameter int                 T_S1        = DEF_T_S1,
  parameter int                 T_S1L       = DEF_T_S1L,
  parameter int                 T_S2        = DEF_T_S2,
  parameter int                 T_GOT       = DEF_T_GOT,
  parameter int                 T_ALARM     = DEF_T_ALARM
) (
  input  logic               __clk,
  input  logic               clo,
  input  logic [NSTATES-1:0] enter,
  input  logic [NSTATES-1:0] set,
  input  logic               mode,
  input  logic               step,
  input  logic               strob_fp,
  px_seq_if.master           bus,
  output logic [NSTATES-1:0] state,
  output logic               strob1,
  output logic               strob2,
  output logic               got,
  output logic               busy
);

  localparam int CW = cnt_width(T_S1, T_S1L, T_S2, T_GOT, T_ALARM);

  localparam logic [CW-1:0] S1_LEN  = CW'(T_S1);
  localparam logic [CW-1:0] S1L_LEN = CW'(T_S1L);
  localparam logic [CW-1:0] S2_LEN  = CW'(T_S2);
  localparam logic [CW-1:0] GOT_LEN = CW'(T_GOT);
  localparam logic [CW-1:0] AL_LEN  = CW'(T_ALARM - 1);

  localparam logic [CW-1:0] RST_S1_LEN = (|(RESET_STATE & LONG_MASK)) ? S1L_LEN : S1_LEN;
  localparam logic          RST_BUS    = |(RESET_STATE & BUS_MASK);
  localparam logic          RST_S2     = |(RESET_STATE & S2_MASK);

  px_seq_t            seq_q, seq_nxt;
  logic [NSTATES-1:0] state_q, state_nxt;
  logic               strob1_q, strob1_nxt;
  logic               strob2_q, strob2_nxt;
  logic               got_q, got_nxt;
  logic               busy_q, busy_nxt;
  logic               zg_q, zg_nxt;
  logic               ok_q, ok_nxt;
  logic               en_flag_q, en_flag_nxt;
  logic               alarm_q, alarm_nxt;
  logic               is_bus_q, is_bus_nxt;
  logic               is_s2_q, is_s2_nxt;
  logic               got_first_q, got_first_nxt;
  logic               step_q;

  logic               ph_load, ph_en, ph_done, ph_active, ph_end;
  logic [CW-1:0]      ph_val;
  logic               al_load, al_en, al_done;
  logic               reply, step_rise;
  logic               go_s1, go_wbus, go_s2, go_gate, go_got;

  px_phase_cnt #(.W(CW)) u_phase (
    .clk      (__clk),
    .load     (ph_load),
    .load_val (ph_val),
    .en       (ph_en),
    .done     (ph_done)
  );

  px_phase_cnt #(.W(CW)) u_alarm (
    .clk      (__clk),
    .load     (al_load),
    .load_val (AL_LEN),
    .en       (al_en),
    .done     (al_done)
  );

  // The first S1 cycle after clo has strob1 low and must not consume
  // phase time, so S1 only counts while its strobe is actually up.
  assign ph_active = ((seq_q == S1) && strob1_q) || (seq_q == S2) || (seq_q == GOT);
  assign ph_en     = ph_active;
  assign ph_end    = ph_active && ph_done;
  assign al_en     = (seq_q == WBUS);
  assign reply     = bus.zw & (bus.rok | bus.ren);
  assign step_rise = step & ~step_q;

  // Next-state and next-output decode; every output is registered from here.
  always_comb begin
    seq_nxt     = seq_q;
    state_nxt   = (seq_q == GOT && got_first_q) ? (enter | set) : (state_q | set);
    zg_nxt      = 1'b0;
    ok_nxt      = 1'b0;
    en_flag_nxt = en_flag_q;
    alarm_nxt   = alarm_q;
    is_bus_nxt  = is_bus_q;
    is_s2_nxt   = is_s2_q;
    ph_load     = 1'b0;
    ph_val      = S1_LEN;
    al_load     = 1'b0;
    go_s1       = 1'b0;
    go_wbus     = 1'b0;
    go_s2       = 1'b0;
    go_gate     = 1'b0;
    go_got      = 1'b0;

    case (seq_q)
      IDLE: begin
        if (|state_q) go_s1 = 1'b1;
      end
      S1: begin
        if (ph_end) begin
          if (is_bus_q)     go_wbus = 1'b1;
          else if (is_s2_q) go_s2   = 1'b1;
          else              go_gate = 1'b1;
        end
      end
      WBUS: begin
        if (ok_q) begin
          if (is_s2_q) go_s2   = 1'b1;
          else         go_gate = 1'b1;
        end else if (reply) begin
          ok_nxt      = 1'b1;
          zg_nxt      = 1'b1;
          en_flag_nxt = bus.ren & ~bus.rok;
        end else if (al_done) begin
          ok_nxt    = 1'b1;
          alarm_nxt = 1'b1;
        end else begin
          zg_nxt = 1'b1;
        end
      end
      S2: begin
        if (ph_end) go_gate = 1'b1;
      end
      WSTEP: begin
        if (step_rise || !mode) go_got = 1'b1;
      end
      GOT: begin
        if (ph_end) begin
          if (|state_nxt) go_s1   = 1'b1;
          else            seq_nxt = IDLE;
        end
      end
      default: seq_nxt = IDLE;
    endcase

    if (go_gate) begin
      if (mode) seq_nxt = WSTEP;
      else      go_got  = 1'b1;
    end

    if (go_s1) begin
      seq_nxt    = S1;
      ph_load    = 1'b1;
      ph_val     = (|(state_nxt & LONG_MASK)) ? S1L_LEN : S1_LEN;
      is_bus_nxt = |(state_nxt & BUS_MASK);
      is_s2_nxt  = |(state_nxt & S2_MASK);
    end

    if (go_wbus) begin
      seq_nxt     = WBUS;
      al_load     = 1'b1;
      zg_nxt      = 1'b1;
      en_flag_nxt = 1'b0;
    end

    if (go_s2) begin
      seq_nxt = S2;
      ph_load = 1'b1;
      ph_val  = S2_LEN;
    end

    if (go_got) begin
      seq_nxt = GOT;
      ph_load = 1'b1;
      ph_val  = GOT_LEN;
    end

    if (clo) begin
      ph_load = 1'b1;
      ph_val  = RST_S1_LEN;
      al_load = 1'b0;
    end

    strob1_nxt    = (seq_nxt == S1) ||
                    (strob_fp && (seq_nxt == IDLE || seq_nxt == WSTEP));
    strob2_nxt    = (seq_nxt == S2);
    got_nxt       = (seq_nxt == GOT);
    busy_nxt      = !(seq_nxt == IDLE || seq_nxt == WSTEP);
    got_first_nxt = (seq_nxt == GOT) && (seq_q != GOT);
  end

  // Sequencer and output registers; clo restarts at S1 of RESET_STATE.
  always_ff @(posedge __clk) begin
    if (clo) begin
      seq_q       <= S1;
      state_q     <= RESET_STATE;
      strob1_q    <= 1'b0;
      strob2_q    <= 1'b0;
      got_q       <= 1'b0;
      busy_q      <= 1'b1;
      zg_q        <= 1'b0;
      ok_q        <= 1'b0;
      en_flag_q   <= 1'b0;
      alarm_q     <= 1'b0;
      is_bus_q    <= RST_BUS;
      is_s2_q     <= RST_S2;
      got_first_q <= 1'b0;
      step_q      <= step;
    end else begin
      seq_q       <= seq_nxt;
      state_q     <= state_nxt;
      strob1_q    <= strob1_nxt;
      strob2_q    <= strob2_nxt;
      got_q       <= got_nxt;
      busy_q      <= busy_nxt;
      zg_q        <= zg_nxt;
      ok_q        <= ok_nxt;
      en_flag_q   <= en_flag_nxt;
      alarm_q     <= alarm_nxt;
      is_bus_q    <= is_bus_nxt;
      is_s2_q     <= is_s2_nxt;
      got_first_q <= got_first_nxt;
      step_q      <= step;
    end
  end

  assign state       = state_q;
  assign strob1      = strob1_q;
  assign strob2      = strob2_q;
  assign got         = got_q;
  assign busy        = busy_q;
  assign bus.zg      = zg_q;
  assign bus.ok      = ok_q;
  assign bus.en_flag = en_flag_q;
  assign bus.alarm   = alarm_q;

endmodule
